// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : disp_pkg
//  Purpose  : Shared constants and types for the seven-segment display
//             arbiter: one-hot state encoding, default hold time, client
//             indices, the blank-all mask and the leading-zero blank helper.
//  Revision : 1.0  initial release
// ============================================================================
package disp_pkg;

   // Default minimum grant tenure: 1 s at 50 MHz.
   localparam int HOLD_CYCLES_DEF = 50_000_000;

   // Client indices, also used as the value of the last-grant pointer.
   localparam logic CLIENT_A = 1'b0;
   localparam logic CLIENT_B = 1'b1;

   // All four digits dark.
   localparam logic [3:0] BLANK_ALL = 4'b1111;

   // One-hot state encoding. The SHOW_A / SHOW_B bits are used directly
   // as the registered grant outputs.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'b001,
      ST_SHOW_A = 3'b010,
      ST_SHOW_B = 3'b100
   } state_e;

   localparam int STATE_BIT_A = 1;
   localparam int STATE_BIT_B = 2;

   // Leading-zero blank mask for a packed {dig3,dig2,dig1,dig0} word.
   // dig0 is never blanked so a value of zero still shows a single "0".
   function automatic logic [3:0] lz_blank(input logic [15:0] digits);
      logic [3:0] mask;
      mask    = 4'b0000;
      mask[3] = (digits[15:12] == 4'h0);
      mask[2] = mask[3] && (digits[11:8] == 4'h0);
      mask[1] = mask[2] && (digits[7:4] == 4'h0);
      return mask;
   endfunction

endpackage : disp_pkg
`default_nettype wire

// File: rtl/hold_timer.sv
`default_nettype none
// ============================================================================
//  Module   : hold_timer
//  Purpose  : Grant-tenure counter. Loads on request, otherwise counts down
//             once per cycle and saturates at zero.
//  Ports    : clk      - system clock
//             rst      - asynchronous active-low reset (counter -> 0)
//             load     - load load_val this cycle (wins over decrement)
//             load_val - reload value, CNT_W bits
//             zero     - counter currently equals zero
//  Revision : 1.0  initial release
// ============================================================================
module hold_timer #(
   parameter int CNT_W = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule : hold_timer
`default_nettype wire

// File: rtl/disp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : disp_arbiter
//  Purpose  : Shares a four-digit seven-segment display between two clients
//             (A and B). Grants one client at a time with a guaranteed
//             minimum tenure of HOLD_CYCLES cycles and round-robin fairness
//             on ties, and drives registered digit codes plus a blank mask.
//  Ports    : clk            - system clock, rising edge
//             rst            - asynchronous active-low reset
//             req_a / req_b  - client display requests
//             val_a / val_b  - client digits {dig3,dig2,dig1,dig0}
//             gnt_a / gnt_b  - registered grants, never both high
//             dig0..dig3     - registered digit codes to the decoders
//             blank          - bit i high forces digit i dark
//             busy           - gnt_a | gnt_b
//  Config   : DISP_LZ_BLANK_EN - when defined, leading zeros of the shown
//             value are blanked while granted (dig0 always lit).
//  Revision : 1.0  initial release
// ============================================================================
module disp_arbiter
   import disp_pkg::*;
#(
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_a,
   input  logic [15:0] val_a,
   input  logic        req_b,
   input  logic [15:0] val_b,
   output logic        gnt_a,
   output logic        gnt_b,
   output logic [3:0]  dig0,
   output logic [3:0]  dig1,
   output logic [3:0]  dig2,
   output logic [3:0]  dig3,
   output logic [3:0]  blank,
   output logic        busy
);

   // Counter only has to hold HOLD_CYCLES-1, so clog2 of HOLD_CYCLES is
   // sufficient; HOLD_CYCLES=1 still needs a one-bit register.
   localparam int               CNT_W       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);

   state_e      state_q;
   state_e      state_d;
   logic        last_q;
   logic        last_d;
   logic [15:0] dig_q;
   logic [15:0] dig_d;
   logic [3:0]  blank_q;
   logic [3:0]  blank_d;
   logic        hold_load;
   logic        hold_zero;

   hold_timer #(
      .CNT_W    (CNT_W)
   ) u_hold_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (hold_load),
      .load_val (HOLD_RELOAD),
      .zero     (hold_zero)
   );

   // ------------------------------------------------------------------------
   // Next-state, pointer and digit logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      dig_d     = dig_q;
      hold_load = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // A wins a tie unless A was the last owner.
            if (req_a && (!req_b || (last_q == CLIENT_B))) begin
               state_d   = ST_SHOW_A;
               last_d    = CLIENT_A;
               dig_d     = val_a;
               hold_load = 1'b1;
            end else if (req_b) begin
               state_d   = ST_SHOW_B;
               last_d    = CLIENT_B;
               dig_d     = val_b;
               hold_load = 1'b1;
            end
         end

         ST_SHOW_A: begin
            if (hold_zero && req_b) begin
               // Direct hand-over, no IDLE gap.
               state_d   = ST_SHOW_B;
               last_d    = CLIENT_B;
               dig_d     = val_b;
               hold_load = 1'b1;
            end else begin
               if (hold_zero) begin
                  if (req_a) begin
                     hold_load = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
               // Digits follow the owner only while it keeps requesting;
               // otherwise the last latched value stays on display.
               if (req_a) begin
                  dig_d = val_a;
               end
            end
         end

         ST_SHOW_B: begin
            if (hold_zero && req_a) begin
               state_d   = ST_SHOW_A;
               last_d    = CLIENT_A;
               dig_d     = val_a;
               hold_load = 1'b1;
            end else begin
               if (hold_zero) begin
                  if (req_b) begin
                     hold_load = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
               if (req_b) begin
                  dig_d = val_b;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Blank mask, derived from the next digit value so it is registered in
   // the same edge as the digits it describes.
   // ------------------------------------------------------------------------
   always_comb begin
      blank_d = BLANK_ALL;
      if (state_d != ST_IDLE) begin
`ifdef DISP_LZ_BLANK_EN
         blank_d = lz_blank(dig_d);
`else
         blank_d = 4'b0000;
`endif
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         last_q  <= CLIENT_B;
         dig_q   <= 16'h0000;
         blank_q <= BLANK_ALL;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         dig_q   <= dig_d;
         blank_q <= blank_d;
      end
   end

   // Grants are the one-hot state bits themselves, so they are registered
   // and mutually exclusive by construction.
   assign gnt_a = state_q[STATE_BIT_A];
   assign gnt_b = state_q[STATE_BIT_B];
   assign busy  = gnt_a | gnt_b;

   assign dig3  = dig_q[15:12];
   assign dig2  = dig_q[11:8];
   assign dig1  = dig_q[7:4];
   assign dig0  = dig_q[3:0];
   assign blank = blank_q;

endmodule : disp_arbiter
`default_nettype wire

// File: tb/tb_disp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_disp_arbiter
//  Purpose  : Self-checking bench for disp_arbiter with HOLD_CYCLES=4.
//             Stimulus pushes hand-computed expected outputs into a queue;
//             a monitor pops and compares after each clock edge (or after
//             an asynchronous reset event).
//  Config   : DISP_LZ_BLANK_EN selects the expected blank masks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_disp_arbiter;

   typedef struct packed {
      logic        ga;
      logic        gb;
      logic [15:0] dig;
      logic [3:0]  blank;
   } exp_t;

`ifdef DISP_LZ_BLANK_EN
   localparam logic [3:0] BL_0070 = 4'b1100;
   localparam logic [3:0] BL_0000 = 4'b1110;
`else
   localparam logic [3:0] BL_0070 = 4'b0000;
   localparam logic [3:0] BL_0000 = 4'b0000;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_a = 1'b0;
   logic [15:0] val_a = 16'h0000;
   logic        req_b = 1'b0;
   logic [15:0] val_b = 16'h0000;
   logic        gnt_a;
   logic        gnt_b;
   logic [3:0]  dig0;
   logic [3:0]  dig1;
   logic [3:0]  dig2;
   logic [3:0]  dig3;
   logic [3:0]  blank;
   logic        busy;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    errors = 0;
   event  ev_chk;

   always #5 clk = ~clk;

   disp_arbiter #(
      .HOLD_CYCLES (4)
   ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .req_a (req_a),
      .val_a (val_a),
      .req_b (req_b),
      .val_b (val_b),
      .gnt_a (gnt_a),
      .gnt_b (gnt_b),
      .dig0  (dig0),
      .dig1  (dig1),
      .dig2  (dig2),
      .dig3  (dig3),
      .blank (blank),
      .busy  (busy)
   );

   // Drive one cycle of inputs on the falling edge and queue the outputs
   // expected after the following rising edge.
   task automatic cyc(input logic ra, input logic [15:0] va,
                      input logic rb, input logic [15:0] vb,
                      input logic ga, input logic gb,
                      input logic [15:0] d, input logic [3:0] bl,
                      input string nm);
      exp_t e;
      @(negedge clk);
      req_a = ra;
      val_a = va;
      req_b = rb;
      val_b = vb;
      e.ga    = ga;
      e.gb    = gb;
      e.dig   = d;
      e.blank = bl;
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // Assert reset between edges and check the outputs before the next edge.
   task automatic async_reset();
      exp_t e;
      @(negedge clk);
      #2;
      rst = 1'b0;
      e.ga    = 1'b0;
      e.gb    = 1'b0;
      e.dig   = 16'h0000;
      e.blank = 4'b1111;
      exp_q.push_back(e);
      name_q.push_back("rst_async");
      -> ev_chk;
   endtask

   // Monitor / scoreboard
   initial begin
      exp_t  e;
      string nm;
      logic [22:0] act;
      logic [22:0] req;
      forever begin
         @(posedge clk or ev_chk);
         #1;
         if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {gnt_a, gnt_b, busy, dig3, dig2, dig1, dig0, blank};
            req = {e.ga, e.gb, e.ga | e.gb, e.dig, e.blank};
            checks++;
            if (act !== req) begin
               errors++;
               $display("FAIL %s: got gnt_a=%b gnt_b=%b busy=%b dig=%h blank=%b, expected gnt_a=%b gnt_b=%b busy=%b dig=%h blank=%b",
                        nm, act[22], act[21], act[20], act[19:4], act[3:0],
                        req[22], req[21], req[20], req[19:4], req[3:0]);
            end
         end
      end
   end

   // Stimulus
   initial begin
      // Reset held: reset values.
      repeat (2) cyc(0, 16'h0, 0, 16'h0, 0, 0, 16'h0000, 4'b1111, "rst_hold");
      @(negedge clk);
      rst = 1'b1;
      repeat (3) cyc(0, 16'h0, 0, 16'h0, 0, 0, 16'h0000, 4'b1111, "idle");

      // Constant dual request: A, B, A, B in 4-cycle tenures, no IDLE gap.
      repeat (4) cyc(1, 16'h1234, 1, 16'h9abc, 1, 0, 16'h1234, 4'b0000, "dual_a1");
      repeat (4) cyc(1, 16'h1234, 1, 16'h9abc, 0, 1, 16'h9abc, 4'b0000, "dual_b1");
      repeat (4) cyc(1, 16'h1234, 1, 16'h9abc, 1, 0, 16'h1234, 4'b0000, "dual_a2");
      cyc(1, 16'h1234, 1, 16'h9abc, 0, 1, 16'h9abc, 4'b0000, "dual_b2");
      repeat (3) cyc(0, 16'h1234, 0, 16'h5555, 0, 1, 16'h9abc, 4'b0000, "b_drop");
      cyc(0, 16'h1234, 0, 16'h5555, 0, 0, 16'h9abc, 4'b1111, "b_expire");

      // A alone, digits track val_a with one cycle of latency.
      repeat (3) cyc(1, 16'h1234, 0, 16'h0, 1, 0, 16'h1234, 4'b0000, "a_grant");
      cyc(1, 16'h5678, 0, 16'h0, 1, 0, 16'h5678, 4'b0000, "a_track");
      cyc(1, 16'h5678, 0, 16'h0, 1, 0, 16'h5678, 4'b0000, "a_renew");
      repeat (3) cyc(0, 16'h5678, 0, 16'h0, 1, 0, 16'h5678, 4'b0000, "a_hold");
      cyc(0, 16'h5678, 0, 16'h0, 0, 0, 16'h5678, 4'b1111, "a_expire");

      // A drops after one cycle: grant persists with frozen digits.
      cyc(1, 16'h4321, 0, 16'h0, 1, 0, 16'h4321, 4'b0000, "drop_grant");
      repeat (3) cyc(0, 16'hffff, 0, 16'h0, 1, 0, 16'h4321, 4'b0000, "drop_frozen");
      cyc(0, 16'hffff, 0, 16'h0, 0, 0, 16'h4321, 4'b1111, "drop_idle");

      // B granted, then asynchronous reset mid-tenure.
      repeat (2) cyc(0, 16'h0, 1, 16'h2468, 0, 1, 16'h2468, 4'b0000, "b_grant");
      async_reset();
      cyc(0, 16'h0, 0, 16'h0, 0, 0, 16'h0000, 4'b1111, "rst_async_edge");
      @(negedge clk);
      rst = 1'b1;

      // After reset the pointer is B again, so a dual request grants A.
      cyc(1, 16'h1234, 1, 16'h9abc, 1, 0, 16'h1234, 4'b0000, "post_rst_dual");

      // Leading-zero blanking patterns while A owns the display.
      cyc(1, 16'h0070, 0, 16'h0, 1, 0, 16'h0070, BL_0070, "lz_0070");
      repeat (3) cyc(1, 16'h0000, 0, 16'h0, 1, 0, 16'h0000, BL_0000, "lz_0000");
      repeat (3) cyc(0, 16'h0000, 0, 16'h0, 1, 0, 16'h0000, BL_0000, "lz_hold");
      cyc(0, 16'h0000, 0, 16'h0, 0, 0, 16'h0000, 4'b1111, "lz_idle");

      // Let the monitor drain every queued expectation.
      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_disp_arbiter
`default_nettype wire
